// File: rtl/cpu_consts.sv
// Shared CPU constants: ALU op codes, operand-source selects and the issue-queue micro-op record.
package cpu_consts;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  typedef struct packed {
    logic [3:0]  func;
    logic        word_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic [63:0] opr_a;
    logic [63:0] opr_b;
  } alu_uop_t;

  // x0 is hard-wired to zero, so a writeback to it never patches an operand.
  function automatic logic wb_hit(input logic use_rs, input logic [4:0] rs,
                                  input logic wb_valid, input logic [4:0] wb_rd);
    return use_rs & wb_valid & (rs == wb_rd) & (wb_rd != 5'd0);
  endfunction

endpackage

// File: rtl/alu_issue_queue.sv
// ALU issue queue: buffers decoded micro-ops, resolves and snoops operands,
// and presents the head entry to the ALU.
module alu_issue_queue
  import cpu_consts::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [3:0]  dec_alu_func_i,
  input  logic        dec_word_op_i,
  input  logic [1:0]  dec_src_a_sel_i,
  input  logic        dec_src_b_sel_i,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic [4:0]  dec_rd_i,
  input  logic [63:0] dec_rs1_data_i,
  input  logic [63:0] dec_rs2_data_i,
  input  logic [63:0] dec_imm_i,
  input  logic [63:0] dec_pc_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [63:0] wb_data_i,
  input  logic        flush_i,
  input  logic        ex_ready_i,
  output logic        alu_valid_o,
  output logic [3:0]  alu_func_o,
  output logic        word_op_o,
  output logic [63:0] opr_a_o,
  output logic [63:0] opr_b_o,
  output logic [4:0]  rd_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  alu_uop_t         ent_q [DEPTH];
  alu_uop_t         ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             enq_s, deq_s;

  function automatic alu_uop_t build_uop(
    input logic [3:0]  func,
    input logic        word_op,
    input logic [1:0]  a_sel,
    input logic        b_sel,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic [63:0] rs1_data,
    input logic [63:0] rs2_data,
    input logic [63:0] imm,
    input logic [63:0] pc,
    input logic        wbv,
    input logic [4:0]  wbrd,
    input logic [63:0] wbdata
  );
    alu_uop_t u;
    u         = '0;
    u.func    = func;
    u.word_op = word_op;
    u.rd      = rd;
    u.rs1     = rs1;
    u.rs2     = rs2;
    u.use_rs1 = (a_sel == SRC_A_RS1);
    u.use_rs2 = (b_sel == SRC_B_RS2);
    case (a_sel)
      SRC_A_RS1: u.opr_a = wb_hit(1'b1, rs1, wbv, wbrd) ? wbdata : rs1_data;
      SRC_A_PC:  u.opr_a = pc;
      default:   u.opr_a = 64'h0;
    endcase
    if (u.use_rs2) begin
      u.opr_b = wb_hit(1'b1, rs2, wbv, wbrd) ? wbdata : rs2_data;
    end else begin
      u.opr_b = imm;
    end
    return u;
  endfunction

  assign dec_ready_o = (count_q != FULL);
  assign alu_valid_o = (count_q != '0);
  assign enq_s       = dec_valid_i & dec_ready_o & ~flush_i;
  assign deq_s       = alu_valid_o & ex_ready_i & ~flush_i;

  // Next-state: writeback snoop on held entries, then enqueue/dequeue/flush bookkeeping.
  always_comb begin
    ent_d    = ent_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && wb_hit(ent_q[i].use_rs1, ent_q[i].rs1, wb_valid_i, wb_rd_i)) begin
        ent_d[i].opr_a = wb_data_i;
      end else begin
        ent_d[i].opr_a = ent_q[i].opr_a;
      end
      if (vld_q[i] && wb_hit(ent_q[i].use_rs2, ent_q[i].rs2, wb_valid_i, wb_rd_i)) begin
        ent_d[i].opr_b = wb_data_i;
      end else begin
        ent_d[i].opr_b = ent_q[i].opr_b;
      end
    end
    if (enq_s) begin
      ent_d[wr_ptr_q] = build_uop(dec_alu_func_i, dec_word_op_i, dec_src_a_sel_i, dec_src_b_sel_i,
                                  dec_rs1_i, dec_rs2_i, dec_rd_i, dec_rs1_data_i, dec_rs2_data_i,
                                  dec_imm_i, dec_pc_i, wb_valid_i, wb_rd_i, wb_data_i);
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      count_d = count_d;
    end
  end

  // Queue state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_q    <= ent_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head presentation with word-shift conditioning of operand A; zeros when empty.
  always_comb begin
    alu_func_o = 4'd0;
    word_op_o  = 1'b0;
    rd_o       = 5'd0;
    opr_a_o    = 64'h0;
    opr_b_o    = 64'h0;
    if (alu_valid_o) begin
      alu_func_o = ent_q[rd_ptr_q].func;
      word_op_o  = ent_q[rd_ptr_q].word_op;
      rd_o       = ent_q[rd_ptr_q].rd;
      opr_b_o    = ent_q[rd_ptr_q].opr_b;
      if (ent_q[rd_ptr_q].word_op && ent_q[rd_ptr_q].func == OP_SRL) begin
        opr_a_o = {32'h0, ent_q[rd_ptr_q].opr_a[31:0]};
      end else if (ent_q[rd_ptr_q].word_op && ent_q[rd_ptr_q].func == OP_SRA) begin
        opr_a_o = {{32{ent_q[rd_ptr_q].opr_a[31]}}, ent_q[rd_ptr_q].opr_a[31:0]};
      end else begin
        opr_a_o = ent_q[rd_ptr_q].opr_a;
      end
    end else begin
      opr_a_o = 64'h0;
    end
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Producer side of the combinational ALU.
- Buffers decoded ALU micro-ops from decode in a small FIFO and resolves operand A/B sources (rs1/pc/zero, rs2/imm).
- Snoops writeback to patch stale register operands, and conditions word-shift operands.
- Presents the head entry to the ALU with a valid/ready handshake toward writeback. Flush empties the queue.

Parameters:
- DEPTH, 2, number of queue entries; power of two, ≥2.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- dec_valid_i  in  1  decode offers a micro-op.
- dec_ready_o  out  1  queue can accept.
- dec_alu_func_i  in  4  OP_* code from cpu_consts.
- dec_word_op_i  in  1  RV64 *W instruction.
- dec_src_a_sel_i  in  2  SRC_A_RS1 / SRC_A_PC / SRC_A_ZERO.
- dec_src_b_sel_i  in  1  SRC_B_RS2 / SRC_B_IMM.
- dec_rs1_i, dec_rs2_i, dec_rd_i  in  5 each  register indices.
- dec_rs1_data_i, dec_rs2_data_i, dec_imm_i, dec_pc_i  in  64 each  operand candidates.
- wb_valid_i  in  1  writeback writes register file this cycle.
- wb_rd_i  in  5  writeback destination.
- wb_data_i  in  64  writeback value.
- flush_i  in  1  pipeline flush.
- ex_ready_i  in  1  downstream accepts the head result.
- alu_valid_o  out  1  head entry valid.
- alu_func_o  out  4  head OP_* code.
- word_op_o  out  1  head word-op flag.
- opr_a_o, opr_b_o  out  64 each  ALU operands.
- rd_o  out  5  head destination.

Behaviour:
- Reset (async, resetn=0): count=0, read/write pointers=0, all entry valid bits 0. alu_valid_o=0, dec_ready_o=1, all head data outputs 0.
- Clocked state updates on the rising edge of clk.
- dec_ready_o = (count != DEPTH). It is combinational from count only; no dependence on ex_ready_i and no pass-through when full.
- Enqueue when dec_valid_i & dec_ready_o & ~flush_i:
  - Write the entry at the write pointer; the pointer wraps modulo DEPTH.
  - Operand A: rs1 data, dec_pc_i, or 64'h0 per dec_src_a_sel_i. Select value 3 gives 0.
  - Operand B: rs2 data or dec_imm_i per dec_src_b_sel_i.
  - Each entry stores rs1/rs2 indices plus use_rs1/use_rs2 flags. A flag is set only when that operand was sourced from a register.
- Writeback snoop, every cycle:
  - For each valid entry with use_rsN=1, rsN==wb_rd_i, wb_rd_i!=0 and wb_valid_i=1: overwrite the stored operand with wb_data_i.
  - The enqueue path applies the same bypass to dec_rs*_data_i in the same cycle.
  - Index x0 never matches.
- Head output: alu_valid_o = (count != 0). When empty, all data outputs are 0.
- Word-shift conditioning, applied at the output after the snoop value:
  - word_op & OP_SRL: opr_a_o = {32'h0, a[31:0]}.
  - word_op & OP_SRA: opr_a_o = {{32{a[31]}}, a[31:0]}.
  - All other cases: opr_a_o = stored A.
  - opr_b_o is always stored B.
- Dequeue when alu_valid_o & ex_ready_i & ~flush_i; the read pointer advances with wrap.
- Count: simultaneous enqueue+dequeue leaves count unchanged. Enqueue alone gives +1, dequeue alone gives -1.
- Minimum latency is 1 cycle from enqueue to alu_valid_o; there is no combinational decode→ALU path.
- Flush (flush_i=1):
  - Next edge: count=0, pointers=0, all entries invalid.
  - Enqueue and dequeue in the flush cycle are suppressed.
  - alu_valid_o may still be 1 during the flush cycle; the ALU masks it.
- Reset asserted mid-operation discards all entries immediately.

Decomposition:
- Add to the cpu_consts package:
  - SRC_A_RS1=2'd0, SRC_A_PC=2'd1, SRC_A_ZERO=2'd2.
  - SRC_B_RS2=1'b0, SRC_B_IMM=1'b1.
  - Packed struct alu_uop_t: func[3:0], word_op, rd[4:0], rs1[4:0], rs2[4:0], use_rs1, use_rs2, opr_a[63:0], opr_b[63:0].
- OP_* codes are reused from cpu_consts.
- Single module; the operand mux plus bypass is a local function. No sub-module is required.

Test Plan:
- Reset then ADD, rs1_data=5, imm=7, src_b=IMM, ex_ready=1 → next cycle alu_valid_o=1, opr_a=5, opr_b=7, func=OP_ADD; one cycle later alu_valid_o=0.
- ex_ready=0, enqueue 3 ops with DEPTH=2 → dec_ready_o=0 after the 2nd; the 3rd is held. Releasing ex_ready drains the ops in order with correct rd_o values.
- Queued op uses rs1=x3; wb_valid=1, wb_rd=3, wb_data=64'hDEAD while the op waits → opr_a_o=64'hDEAD. The same sequence with wb_rd=0 and rs1=x0 → operand unchanged.
- SRAW with rs1_data=64'h0000_0000_8000_0000 → opr_a_o=64'hFFFF_FFFF_8000_0000. SRLW with rs1_data=64'hFFFF_FFFF_0000_0010 → opr_a_o=64'h0000_0000_0000_0010.
- Queue full with 2 entries, flush_i=1 while dec_valid=1 → next cycle alu_valid_o=0, count=0, and the offered op is not enqueued.
- Pointer wrap: 10 back-to-back ops with ex_ready toggling 1/0 → FIFO order preserved with no loss or duplication. Asserting resetn=0 mid-stream → alu_valid_o=0 asynchronously.
